oq_mcast_header_parser: RTL and testbench

OQ_MCAST_HEADER_PARSER -- requirements
Module: oq_mcast_header_parser

---
 rtl/oq_mcast_header_parser_if.sv | 41 ++++
 rtl/oq_mcast_header_parser.sv | 214 +++++++++++++++++++++
 tb/tb_oq_mcast_header_parser.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/oq_mcast_header_parser_if.sv
// Bus bundle for the multicast header parser: the packet word stream in,
// and the descriptor FIFO head, flow-control and error pulses out.
interface oq_mcast_header_parser_if #(
  parameter int DATA_WIDTH         = 64,
  parameter int CTRL_WIDTH         = DATA_WIDTH / 8,
  parameter int NUM_OUTPUT_QUEUES  = 8,
  parameter int NUM_OQ_WIDTH       = (NUM_OUTPUT_QUEUES > 1) ? $clog2(NUM_OUTPUT_QUEUES) : 1,
  parameter int MAX_PKT            = 2048,
  parameter int PKT_BYTE_CNT_WIDTH = $clog2(MAX_PKT),
  parameter int PKT_WORD_CNT_WIDTH = $clog2(MAX_PKT / CTRL_WIDTH)
);
  logic                          in_wr;
  logic [CTRL_WIDTH-1:0]         in_ctrl;
  logic [DATA_WIDTH-1:0]         in_data;
  logic                          rd_dst_oq;
  logic [NUM_OUTPUT_QUEUES-1:0]  parsed_dst_mask;
  logic [NUM_OQ_WIDTH-1:0]       parsed_first_oq;
  logic [NUM_OQ_WIDTH:0]         parsed_num_dst;
  logic [PKT_BYTE_CNT_WIDTH-1:0] parsed_pkt_byte_len;
  logic [PKT_WORD_CNT_WIDTH-1:0] parsed_pkt_word_len;
  logic                          parsed_drop;
  logic                          dst_oq_avail;
  logic                          header_parser_rdy;
  logic                          err_no_hdr;
  logic                          err_overflow;
  logic                          err_len;

  modport master (
    output in_wr, in_ctrl, in_data, rd_dst_oq,
    input  parsed_dst_mask, parsed_first_oq, parsed_num_dst, parsed_pkt_byte_len,
           parsed_pkt_word_len, parsed_drop, dst_oq_avail, header_parser_rdy,
           err_no_hdr, err_overflow, err_len
  );

  modport slave (
    input  in_wr, in_ctrl, in_data, rd_dst_oq,
    output parsed_dst_mask, parsed_first_oq, parsed_num_dst, parsed_pkt_byte_len,
           parsed_pkt_word_len, parsed_drop, dst_oq_avail, header_parser_rdy,
           err_no_hdr, err_overflow, err_len
  );
endinterface

// File: rtl/oq_mcast_header_parser.sv
// Parses the IOQ module header of each packet into a destination descriptor
// (multicast mask, first queue, fan-out, lengths, drop) held in a fallthrough FIFO.
`ifndef IO_QUEUE_STAGE_NUM
`define IO_QUEUE_STAGE_NUM 8'hff
`endif
`ifndef IOQ_BYTE_LEN_POS
`define IOQ_BYTE_LEN_POS 0
`endif
`ifndef IOQ_WORD_LEN_POS
`define IOQ_WORD_LEN_POS 32
`endif
`ifndef IOQ_DST_PORT_POS
`define IOQ_DST_PORT_POS 48
`endif

module oq_mcast_header_parser #(
  parameter int                    DATA_WIDTH         = 64,
  parameter int                    CTRL_WIDTH         = DATA_WIDTH / 8,
  parameter logic [CTRL_WIDTH-1:0] IOQ_STAGE_NUM      = `IO_QUEUE_STAGE_NUM,
  parameter int                    NUM_OUTPUT_QUEUES  = 8,
  parameter int                    NUM_OQ_WIDTH       = (NUM_OUTPUT_QUEUES > 1) ? $clog2(NUM_OUTPUT_QUEUES) : 1,
  parameter int                    MAX_PKT            = 2048,
  parameter int                    PKT_BYTE_CNT_WIDTH = $clog2(MAX_PKT),
  parameter int                    PKT_WORD_CNT_WIDTH = $clog2(MAX_PKT / CTRL_WIDTH),
  parameter int                    FIFO_DEPTH_BITS    = 2
) (
  input logic                     clk,
  input logic                     reset,
  oq_mcast_header_parser_if.slave bus
);
  localparam int DEPTH      = 1 << FIFO_DEPTH_BITS;
  localparam int CNT_W      = FIFO_DEPTH_BITS + 1;
  localparam int LEN_W      = PKT_BYTE_CNT_WIDTH + 1;
  localparam int WORD_SHIFT = $clog2(CTRL_WIDTH);

  typedef enum logic [1:0] {
    WAIT_HDR  = 2'd0,
    WAIT_DATA = 2'd1,
    WAIT_EOP  = 2'd2
  } state_t;

  function automatic logic [NUM_OQ_WIDTH-1:0] lowest_set(input logic [NUM_OUTPUT_QUEUES-1:0] mask);
    lowest_set = {NUM_OQ_WIDTH{1'b0}};
    for (int i = NUM_OUTPUT_QUEUES - 1; i >= 0; i--) begin
      if (mask[i]) lowest_set = NUM_OQ_WIDTH'(i);
    end
  endfunction

  function automatic logic [NUM_OQ_WIDTH:0] pop_count(input logic [NUM_OUTPUT_QUEUES-1:0] mask);
    pop_count = {(NUM_OQ_WIDTH + 1){1'b0}};
    for (int i = 0; i < NUM_OUTPUT_QUEUES; i++) begin
      pop_count = pop_count + {{NUM_OQ_WIDTH{1'b0}}, mask[i]};
    end
  endfunction

  state_t                        state;
  state_t                        state_next;
  logic                          hdr_take;
  logic                          no_hdr;
  logic                          eop_end;
  logic                          is_hdr;
  logic                          is_data;
  logic                          is_eop;
  logic [PKT_WORD_CNT_WIDTH-1:0] word_cnt;
  logic [PKT_WORD_CNT_WIDTH-1:0] exp_word_len;
  logic                          hdr_seen;
  logic                          len_bad;
  logic                          err_no_hdr_q;
  logic                          err_overflow_q;
  logic                          err_len_q;

  logic [NUM_OUTPUT_QUEUES-1:0]  hdr_mask;
  logic [PKT_BYTE_CNT_WIDTH-1:0] hdr_byte_len;
  logic [PKT_WORD_CNT_WIDTH-1:0] hdr_word_len;
  logic [LEN_W-1:0]              hdr_ceil_words;
  logic                          hdr_drop;

  logic [FIFO_DEPTH_BITS-1:0]    wr_ptr;
  logic [FIFO_DEPTH_BITS-1:0]    rd_ptr;
  logic [CNT_W-1:0]              count;
  logic                          full;
  logic                          avail;
  logic                          wr_en;
  logic                          rd_en;
  logic                          unused_data;

  logic [NUM_OUTPUT_QUEUES-1:0]  mask_mem  [DEPTH];
  logic [NUM_OQ_WIDTH-1:0]       first_mem [DEPTH];
  logic [NUM_OQ_WIDTH:0]         num_mem   [DEPTH];
  logic [PKT_BYTE_CNT_WIDTH-1:0] blen_mem  [DEPTH];
  logic [PKT_WORD_CNT_WIDTH-1:0] wlen_mem  [DEPTH];
  logic                          drop_mem  [DEPTH];

  assign unused_data  = ^bus.in_data;
  assign is_hdr       = bus.in_wr && (bus.in_ctrl == IOQ_STAGE_NUM);
  assign is_data      = bus.in_wr && (bus.in_ctrl == {CTRL_WIDTH{1'b0}});
  assign is_eop       = bus.in_wr && (bus.in_ctrl != {CTRL_WIDTH{1'b0}});

  assign hdr_mask       = bus.in_data[`IOQ_DST_PORT_POS +: NUM_OUTPUT_QUEUES];
  assign hdr_byte_len   = bus.in_data[`IOQ_BYTE_LEN_POS +: PKT_BYTE_CNT_WIDTH];
  assign hdr_word_len   = bus.in_data[`IOQ_WORD_LEN_POS +: PKT_WORD_CNT_WIDTH];
  assign hdr_ceil_words = (LEN_W'(hdr_byte_len) + LEN_W'(CTRL_WIDTH - 1)) >> WORD_SHIFT;
  assign hdr_drop       = (hdr_mask == {NUM_OUTPUT_QUEUES{1'b0}}) ||
                          (LEN_W'(hdr_word_len) != hdr_ceil_words);

  // The word count at EOP excludes the EOP word itself, hence the +1.
  assign len_bad = ({1'b0, word_cnt} + {{PKT_WORD_CNT_WIDTH{1'b0}}, 1'b1}) != {1'b0, exp_word_len};

  assign full  = (count == CNT_W'(DEPTH));
  assign avail = (count != {CNT_W{1'b0}});
  assign wr_en = hdr_take && !full;
  assign rd_en = bus.rd_dst_oq && avail;

  // Parser next state and per-word events.
  always_comb begin
    state_next = state;
    hdr_take   = 1'b0;
    no_hdr     = 1'b0;
    eop_end    = 1'b0;
    case (state)
      WAIT_HDR: begin
        if (is_hdr) begin
          hdr_take   = 1'b1;
          state_next = WAIT_DATA;
        end else if (is_data) begin
          no_hdr     = 1'b1;
          state_next = WAIT_EOP;
        end else begin
          state_next = WAIT_HDR;
        end
      end
      WAIT_DATA: begin
        if (is_data) state_next = WAIT_EOP;
        else         state_next = WAIT_DATA;
      end
      WAIT_EOP: begin
        if (is_eop) begin
          eop_end    = 1'b1;
          state_next = WAIT_HDR;
        end else begin
          state_next = WAIT_EOP;
        end
      end
      default: state_next = WAIT_HDR;
    endcase
  end

  // Parser state, word counter, latched length and error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= WAIT_HDR;
      word_cnt       <= {PKT_WORD_CNT_WIDTH{1'b0}};
      exp_word_len   <= {PKT_WORD_CNT_WIDTH{1'b0}};
      hdr_seen       <= 1'b0;
      err_no_hdr_q   <= 1'b0;
      err_overflow_q <= 1'b0;
      err_len_q      <= 1'b0;
    end else begin
      state          <= state_next;
      err_no_hdr_q   <= no_hdr;
      err_overflow_q <= hdr_take && full;
      err_len_q      <= eop_end && hdr_seen && len_bad;
      if (hdr_take) begin
        word_cnt     <= {PKT_WORD_CNT_WIDTH{1'b0}};
        exp_word_len <= hdr_word_len;
        hdr_seen     <= 1'b1;
      end else begin
        if (is_data || eop_end) word_cnt <= word_cnt + {{(PKT_WORD_CNT_WIDTH - 1){1'b0}}, 1'b1};
        if (eop_end) hdr_seen <= 1'b0;
      end
    end
  end

  // Descriptor FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= {FIFO_DEPTH_BITS{1'b0}};
      rd_ptr <= {FIFO_DEPTH_BITS{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + {{(FIFO_DEPTH_BITS - 1){1'b0}}, 1'b1};
      if (rd_en) rd_ptr <= rd_ptr + {{(FIFO_DEPTH_BITS - 1){1'b0}}, 1'b1};
      case ({wr_en, rd_en})
        2'b10:   count <= count + {{(CNT_W - 1){1'b0}}, 1'b1};
        2'b01:   count <= count - {{(CNT_W - 1){1'b0}}, 1'b1};
        default: count <= count;
      endcase
    end
  end

  // Descriptor storage; contents are only visible while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mask_mem[wr_ptr]  <= hdr_mask;
      first_mem[wr_ptr] <= lowest_set(hdr_mask);
      num_mem[wr_ptr]   <= pop_count(hdr_mask);
      blen_mem[wr_ptr]  <= hdr_byte_len;
      wlen_mem[wr_ptr]  <= hdr_word_len;
      drop_mem[wr_ptr]  <= hdr_drop;
    end
  end

  assign bus.parsed_dst_mask     = avail ? mask_mem[rd_ptr]  : {NUM_OUTPUT_QUEUES{1'b0}};
  assign bus.parsed_first_oq     = avail ? first_mem[rd_ptr] : {NUM_OQ_WIDTH{1'b0}};
  assign bus.parsed_num_dst      = avail ? num_mem[rd_ptr]   : {(NUM_OQ_WIDTH + 1){1'b0}};
  assign bus.parsed_pkt_byte_len = avail ? blen_mem[rd_ptr]  : {PKT_BYTE_CNT_WIDTH{1'b0}};
  assign bus.parsed_pkt_word_len = avail ? wlen_mem[rd_ptr]  : {PKT_WORD_CNT_WIDTH{1'b0}};
  assign bus.parsed_drop         = avail ? drop_mem[rd_ptr]  : 1'b0;
  assign bus.dst_oq_avail        = avail;
  assign bus.header_parser_rdy   = !full;
  assign bus.err_no_hdr          = err_no_hdr_q;
  assign bus.err_overflow        = err_overflow_q;
  assign bus.err_len             = err_len_q;
endmodule

// File: tb/tb_oq_mcast_header_parser.sv
// Directed bench for oq_mcast_header_parser: header layout is dst mask at bit 48,
// word length at bit 32, byte length at bit 0; header ctrl is 8'hff.
module tb_oq_mcast_header_parser;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n_nohdr = 0;
  int   n_ovf = 0;
  int   n_len = 0;

  localparam logic [7:0]  HDR_CTRL = 8'hff;
  localparam logic [7:0]  EOP_CTRL = 8'h80;
  localparam logic [63:0] PAYLOAD  = 64'h0123_4567_89ab_cdef;

  oq_mcast_header_parser_if bus ();
  oq_mcast_header_parser dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk_hdr(input logic [7:0] mask, input logic [7:0] wlen, input logic [10:0] blen);
    mk_hdr = (64'(mask) << 48) | (64'(wlen) << 32) | 64'(blen);
  endfunction

  task automatic tick(input logic wr, input logic [7:0] ctrl, input logic [63:0] data, input logic rd);
    bus.in_wr = wr;
    bus.in_ctrl = ctrl;
    bus.in_data = data;
    bus.rd_dst_oq = rd;
    @(posedge clk);
    #1;
    n_nohdr += int'(bus.err_no_hdr);
    n_ovf   += int'(bus.err_overflow);
    n_len   += int'(bus.err_len);
  endtask

  task automatic clr_err();
    n_nohdr = 0;
    n_ovf = 0;
    n_len = 0;
  endtask

  task automatic idle();
    tick(1'b0, 8'h00, 64'h0, 1'b0);
  endtask

  task automatic pop();
    tick(1'b0, 8'h00, 64'h0, 1'b1);
  endtask

  // Header, ndata ctrl==0 words, then one EOP word.
  task automatic send_pkt(input logic [7:0] mask, input logic [7:0] wlen, input logic [10:0] blen, input int ndata);
    tick(1'b1, HDR_CTRL, mk_hdr(mask, wlen, blen), 1'b0);
    for (int i = 0; i < ndata; i++) tick(1'b1, 8'h00, PAYLOAD ^ 64'(i), 1'b0);
    tick(1'b1, EOP_CTRL, PAYLOAD, 1'b0);
  endtask

  task automatic check_head(input string tag, input logic [7:0] mask, input logic [2:0] first,
                            input logic [3:0] num, input logic [10:0] blen, input logic [7:0] wlen,
                            input logic drop);
    check_val({tag, ".avail"}, 64'(bus.dst_oq_avail), 64'd1);
    check_val({tag, ".mask"},  64'(bus.parsed_dst_mask), 64'(mask));
    check_val({tag, ".first"}, 64'(bus.parsed_first_oq), 64'(first));
    check_val({tag, ".num"},   64'(bus.parsed_num_dst), 64'(num));
    check_val({tag, ".blen"},  64'(bus.parsed_pkt_byte_len), 64'(blen));
    check_val({tag, ".wlen"},  64'(bus.parsed_pkt_word_len), 64'(wlen));
    check_val({tag, ".drop"},  64'(bus.parsed_drop), 64'(drop));
  endtask

  task automatic check_empty(input string tag);
    check_val({tag, ".avail"}, 64'(bus.dst_oq_avail), 64'd0);
    check_val({tag, ".rdy"},   64'(bus.header_parser_rdy), 64'd1);
    check_val({tag, ".mask"},  64'(bus.parsed_dst_mask), 64'd0);
    check_val({tag, ".num"},   64'(bus.parsed_num_dst), 64'd0);
    check_val({tag, ".drop"},  64'(bus.parsed_drop), 64'd0);
  endtask

  logic [7:0] fill_mask  [4] = '{8'h80, 8'hff, 8'h01, 8'h48};
  logic [2:0] fill_first [4] = '{3'd7, 3'd0, 3'd0, 3'd3};
  logic [3:0] fill_num   [4] = '{4'd1, 4'd8, 4'd1, 4'd2};

  initial begin
    bus.in_wr = 1'b0;
    bus.in_ctrl = 8'h00;
    bus.in_data = 64'h0;
    bus.rd_dst_oq = 1'b0;
    reset = 1'b1;
    idle();
    idle();
    reset = 1'b0;

    // Reset state
    check_empty("reset");
    check_val("reset.first", 64'(bus.parsed_first_oq), 64'd0);
    check_val("reset.blen", 64'(bus.parsed_pkt_byte_len), 64'd0);
    check_val("reset.wlen", 64'(bus.parsed_pkt_word_len), 64'd0);
    check_val("reset.errs", 64'({bus.err_no_hdr, bus.err_overflow, bus.err_len}), 64'd0);

    // Multicast 0x24, 60 bytes in 8 words
    clr_err();
    tick(1'b1, HDR_CTRL, mk_hdr(8'h24, 8'd8, 11'd60), 1'b0);
    check_val("mc.avail_at_hdr", 64'(bus.dst_oq_avail), 64'd1);
    for (int i = 0; i < 7; i++) tick(1'b1, 8'h00, PAYLOAD, 1'b0);
    tick(1'b1, EOP_CTRL, PAYLOAD, 1'b0);
    check_head("mc", 8'h24, 3'd2, 4'd2, 11'd60, 8'd8, 1'b0);
    check_val("mc.errs", 64'(n_nohdr + n_ovf + n_len), 64'd0);
    pop();
    check_empty("mc.popped");

    // Zero mask
    clr_err();
    send_pkt(8'h00, 8'd2, 11'd16, 1);
    check_head("zero", 8'h00, 3'd0, 4'd0, 11'd16, 8'd2, 1'b1);
    check_val("zero.err_len", 64'(n_len), 64'd0);
    pop();

    // Length inconsistent with byte count; body matching / short of word_len
    clr_err();
    send_pkt(8'h03, 8'd9, 11'd64, 8);
    check_head("len9", 8'h03, 3'd0, 4'd2, 11'd64, 8'd9, 1'b1);
    check_val("len9.err_len", 64'(n_len), 64'd0);
    clr_err();
    send_pkt(8'h03, 8'd9, 11'd64, 7);
    check_val("len8.err_len", 64'(n_len), 64'd1);
    pop();
    pop();
    check_val("len.drained", 64'(bus.dst_oq_avail), 64'd0);

    // Fill and overflow
    clr_err();
    for (int i = 0; i < 4; i++) begin
      send_pkt(fill_mask[i], 8'd2, 11'd16, 1);
      if (i == 2) check_val("fill.rdy3", 64'(bus.header_parser_rdy), 64'd1);
    end
    check_val("fill.rdy4", 64'(bus.header_parser_rdy), 64'd0);
    check_val("fill.ovf_before", 64'(n_ovf), 64'd0);
    send_pkt(8'h10, 8'd2, 11'd16, 1);
    check_val("fill.ovf", 64'(n_ovf), 64'd1);
    check_val("fill.len_after_ovf", 64'(n_len), 64'd0);
    for (int i = 0; i < 4; i++) begin
      check_head($sformatf("fill%0d", i), fill_mask[i], fill_first[i], fill_num[i], 11'd16, 8'd2, 1'b0);
      pop();
    end
    check_empty("fill.drained");

    // Pop on empty is ignored; simultaneous read/write keeps occupancy
    pop();
    check_empty("empty_pop");
    send_pkt(8'h11, 8'd2, 11'd16, 1);
    check_head("one", 8'h11, 3'd0, 4'd2, 11'd16, 8'd2, 1'b0);
    tick(1'b1, HDR_CTRL, mk_hdr(8'h06, 8'd2, 11'd16), 1'b1);
    tick(1'b1, 8'h00, PAYLOAD, 1'b0);
    tick(1'b1, EOP_CTRL, PAYLOAD, 1'b0);
    check_head("rdwr", 8'h06, 3'd1, 4'd2, 11'd16, 8'd2, 1'b0);
    pop();
    check_val("rdwr.occupancy", 64'(bus.dst_oq_avail), 64'd0);

    // Missing header: stray non-header ctrl ignored, data word resyncs
    clr_err();
    tick(1'b1, 8'h40, PAYLOAD, 1'b0);
    check_val("nohdr.ctrl_ignored", 64'(n_nohdr), 64'd0);
    tick(1'b1, 8'h00, PAYLOAD, 1'b0);
    check_val("nohdr.pulse", 64'(bus.err_no_hdr), 64'd1);
    tick(1'b1, 8'h00, PAYLOAD, 1'b0);
    tick(1'b1, EOP_CTRL, PAYLOAD, 1'b0);
    check_val("nohdr.count", 64'(n_nohdr), 64'd1);
    check_val("nohdr.no_write", 64'(bus.dst_oq_avail), 64'd0);
    send_pkt(8'h24, 8'd8, 11'd60, 7);
    check_head("nohdr.next", 8'h24, 3'd2, 4'd2, 11'd60, 8'd8, 1'b0);
    check_val("nohdr.next_errs", 64'(n_nohdr + n_len), 64'd1);
    pop();

    // Reset in WAIT_DATA with descriptors queued
    send_pkt(8'h01, 8'd2, 11'd16, 1);
    send_pkt(8'h02, 8'd2, 11'd16, 1);
    tick(1'b1, HDR_CTRL, mk_hdr(8'h0f, 8'd2, 11'd16), 1'b0);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    check_empty("midreset");
    clr_err();
    tick(1'b1, 8'h00, PAYLOAD, 1'b0);
    tick(1'b1, 8'h00, PAYLOAD, 1'b0);
    tick(1'b1, EOP_CTRL, PAYLOAD, 1'b0);
    check_val("midreset.nohdr", 64'(n_nohdr), 64'd1);
    check_val("midreset.no_write", 64'(bus.dst_oq_avail), 64'd0);
    send_pkt(8'h80, 8'd2, 11'd16, 1);
    check_head("midreset.next", 8'h80, 3'd7, 4'd1, 11'd16, 8'd2, 1'b0);
    check_val("midreset.len", 64'(n_len), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
